serv_seq: RTL

SERV_SEQ -- requirements
Module: serv_seq

---
 rtl/serv_seq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/serv_seq.sv
// Bit-serial instruction sequencer: fetch, RF handshake, optional INIT phase, WAIT, RUN.
// Optional misalignment trap latch enabled by defining SERV_SEQ_MISALIGN_TRAP_EN.
//
// state | meaning
// FETCH | instruction bus request outstanding
// READY | waiting for register file read data
// INIT  | first phase of a two-stage op (N beats)
// WAIT  | data bus / register file handoff between phases
// RUN   | execute phase, PC update (N beats)
module serv_seq #(
  parameter int W              = 1,
  parameter     RESET_STRATEGY = "MINI"
) (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic       o_ibus_cyc,
  input  logic       i_ibus_ack,
  output logic       o_rf_rreq,
  output logic       o_rf_wreq,
  input  logic       i_rf_ready,
  input  logic       i_two_stage_op,
  input  logic       i_new_irq,
  input  logic       i_e_op,
  input  logic       i_branch_op,
  input  logic       i_cond_branch,
  input  logic       i_alu_cmp,
  input  logic       i_bne_or_bge,
  input  logic       i_dbus_en,
  input  logic       i_mem_misalign,
  input  logic       i_ctrl_misalign,
  output logic       o_dbus_cyc,
  input  logic       i_dbus_ack,
  output logic       o_cnt_en,
  output logic [4:0] o_cnt_pos,
  output logic       o_cnt_first,
  output logic       o_cnt_done,
  output logic [1:0] o_mem_bytecnt,
  output logic       o_init,
  output logic       o_ctrl_pc_en,
  output logic       o_ctrl_jump,
  output logic       o_ctrl_trap
);

  localparam logic [4:0] STEP = 5'(W);
  localparam logic [4:0] LAST = 5'(32 - W);

  typedef enum logic [2:0] {S_FETCH, S_READY, S_INIT, S_WAIT, S_RUN} state_t;

  state_t     state;
  logic [4:0] pos;
  logic       jump_r;
  logic       irq_r;
  logic       trap_r;
  logic       cnt_en;
  logic       cnt_done;
  logic       jump_next;
  logic       active;

  assign cnt_en    = (state == S_INIT) || (state == S_RUN);
  assign cnt_done  = cnt_en && (pos == LAST);
  assign jump_next = i_branch_op & (~i_cond_branch | (i_alu_cmp ^ i_bne_or_bge));
  assign active    = ~i_rst;

  // Control flops: always reset regardless of RESET_STRATEGY.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_FETCH;
      pos   <= '0;
    end else begin
      // pos wraps to zero on its own since W divides 32
      if (cnt_en) pos <= pos + STEP;
      case (state)
        S_FETCH: if (i_ibus_ack) state <= S_READY;
        S_READY: if (i_rf_ready) state <= (i_two_stage_op && !i_new_irq) ? S_INIT : S_RUN;
        S_INIT:  if (cnt_done) state <= S_WAIT;
        S_WAIT:  if (i_rf_ready) state <= S_RUN;
        S_RUN:   if (cnt_done) state <= S_FETCH;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Interrupt is sampled once in READY and held for the rest of the instruction.
  always_ff @(posedge i_clk) begin
    if (i_rst && (RESET_STRATEGY != "NONE")) begin
      jump_r <= 1'b0;
      irq_r  <= 1'b0;
    end else if (state == S_RUN && cnt_done) begin
      jump_r <= 1'b0;
      irq_r  <= 1'b0;
    end else begin
      if (state == S_READY && i_rf_ready) irq_r <= i_new_irq;
      if (state == S_INIT && cnt_done) jump_r <= jump_next;
    end
  end

`ifdef SERV_SEQ_MISALIGN_TRAP_EN
  always_ff @(posedge i_clk) begin
    if (i_rst && (RESET_STRATEGY != "NONE")) begin
      trap_r <= 1'b0;
    end else if (state == S_RUN && cnt_done) begin
      trap_r <= 1'b0;
    end else if (state == S_INIT && cnt_done) begin
      trap_r <= (i_dbus_en & i_mem_misalign) | (jump_next & i_ctrl_misalign);
    end
  end
`else
  logic unused_misalign;
  assign unused_misalign = i_mem_misalign ^ i_ctrl_misalign;
  assign trap_r          = 1'b0;
`endif

  always_comb begin
    o_ibus_cyc    = active && (state == S_FETCH);
    o_rf_rreq     = active && (((state == S_FETCH) && i_ibus_ack) ||
                               ((state == S_WAIT) && trap_r));
    o_rf_wreq     = active && (state == S_WAIT) && (trap_r || i_dbus_ack || !i_dbus_en);
    o_dbus_cyc    = active && (state == S_WAIT) && i_dbus_en && !trap_r;
    o_cnt_en      = active && cnt_en;
    o_cnt_pos     = active ? pos : 5'd0;
    o_cnt_first   = active && cnt_en && (pos == 5'd0);
    o_cnt_done    = active && cnt_done;
    o_mem_bytecnt = o_cnt_pos[4:3];
    o_init        = active && (state == S_INIT);
    o_ctrl_pc_en  = active && (state == S_RUN);
    o_ctrl_jump   = active && jump_r;
    o_ctrl_trap   = active && (state != S_FETCH) &&
                    (i_e_op || ((state == S_READY) ? i_new_irq : irq_r) || trap_r);
  end

endmodule
